dfu_boot_ctrl: RTL and testbench

Boot/reset sequencer that sits directly downstream of the USB DFU core on the TinyDFU boards.
- Consumes the core's dfu_state and dfu_detach.
- Produces the core reset, the USB pull-up enable, the user-image boot request (drives the FPGA reconfiguration pin via the top-level tristate) and the status LED pattern.
- Replaces the ad-hoc counters in board top levels with one verified block.

---
 rtl/tinydfu_boot_pkg.sv | 29 ++
 rtl/dfu_boot_ctrl_led_pattern.sv | 53 +++++
 rtl/dfu_boot_ctrl.sv | 172 +++++++++++++++++
 tb/tb_dfu_boot_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/tinydfu_boot_pkg.sv
// rtl/tinydfu_boot_pkg.sv - shared types and constants for the TinyDFU boot sequencer
package tinydfu_boot_pkg;

  typedef enum logic [2:0] {
    POR    = 3'd0,
    WAIT   = 3'd1,
    ACTIVE = 3'd2,
    DETACH = 3'd3,
    BOOT   = 3'd4
  } boot_state_e;

  localparam logic [7:0] DFU_STATE_IDLE       = 8'h02;
  localparam logic [7:0] DFU_STATE_ACTIVE_MIN = 8'h03;

  localparam logic [2:0] CYLON_LEFT  = 3'b001;
  localparam logic [2:0] CYLON_MID   = 3'b010;
  localparam logic [2:0] CYLON_RIGHT = 3'b100;

  // The sweep bounces, so step 3 revisits the middle LED.
  function automatic logic [2:0] cylon_pattern(input logic [1:0] step);
    case (step)
      2'd0:    cylon_pattern = CYLON_LEFT;
      2'd1:    cylon_pattern = CYLON_MID;
      2'd2:    cylon_pattern = CYLON_RIGHT;
      default: cylon_pattern = CYLON_MID;
    endcase
  endfunction

endpackage

// File: rtl/dfu_boot_ctrl_led_pattern.sv
// rtl/dfu_boot_ctrl_led_pattern.sv - status LED generator: idle blink or cylon sweep
module dfu_led_pattern
  import tinydfu_boot_pkg::*;
#(
  parameter int BLINK_BIT = 21,
  parameter int CYLON_BIT = 20
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       idle,
  input  logic       blank,
  output logic [2:0] led_n
);

  logic [31:0] cnt_q, cnt_d;
  logic        cyl_prev_q, cyl_prev_d;
  logic [1:0]  step_q, step_d;
  logic [2:0]  led_n_q, led_n_d;

  always_comb begin
    cnt_d      = cnt_q + 32'd1;
    cyl_prev_d = cnt_q[CYLON_BIT];
    step_d     = step_q;
    // Edge detect on a counter bit; the bit itself never clocks anything.
    if (cnt_q[CYLON_BIT] && !cyl_prev_q) begin
      step_d = step_q + 2'd1;
    end
    if (blank) begin
      led_n_d = 3'b111;
    end else if (idle) begin
      led_n_d = ~{2'b00, cnt_q[BLINK_BIT]};
    end else begin
      led_n_d = ~cylon_pattern(step_q);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q      <= 32'd0;
      cyl_prev_q <= 1'b0;
      step_q     <= 2'd0;
      led_n_q    <= 3'b111;
    end else begin
      cnt_q      <= cnt_d;
      cyl_prev_q <= cyl_prev_d;
      step_q     <= step_d;
      led_n_q    <= led_n_d;
    end
  end

  assign led_n = led_n_q;

endmodule

// File: rtl/dfu_boot_ctrl.sv
// rtl/dfu_boot_ctrl.sv - boot/reset sequencer downstream of the USB DFU core
// Optional BOOT_BUTTON_EN adds boot_btn_n to hold the board in DFU mode.
module dfu_boot_ctrl
  import tinydfu_boot_pkg::*;
#(
  parameter int CLK_HZ      = 12000000,
  parameter int POR_CYCLES  = 65535,
  parameter int AUTOBOOT_MS = 5000,
  parameter int DETACH_MS   = 10,
  parameter int BLINK_BIT   = 21,
  parameter int CYLON_BIT   = 20
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] dfu_state,
  input  logic       dfu_detach,
`ifdef BOOT_BUTTON_EN
  input  logic       boot_btn_n,
`endif
  output logic       core_reset,
  output logic       usb_pull_en,
  output logic       boot_now,
  output logic       autoboot_active,
  output logic [2:0] led_n
);

  localparam int AB_CYC = CLK_HZ / 1000 * AUTOBOOT_MS;
  localparam int DT_CYC = CLK_HZ / 1000 * DETACH_MS;
  localparam int POR_W  = $clog2(POR_CYCLES + 1);
  localparam int AB_W   = (AB_CYC > 0) ? $clog2(AB_CYC + 1) : 1;
  localparam int DT_W   = $clog2(DT_CYC + 1);

  boot_state_e     state_q, state_d;
  logic [POR_W-1:0] por_cnt_q, por_cnt_d;
  logic [AB_W-1:0]  ab_cnt_q, ab_cnt_d;
  logic [DT_W-1:0]  dt_cnt_q, dt_cnt_d;
  logic core_reset_q, core_reset_d;
  logic usb_pull_en_q, usb_pull_en_d;
  logic boot_now_q, boot_now_d;
  logic autoboot_active_q, autoboot_active_d;
  logic btn_hold;

`ifdef BOOT_BUTTON_EN
  logic btn_meta_q, btn_sync_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      btn_meta_q <= 1'b1;
      btn_sync_q <= 1'b1;
    end else begin
      btn_meta_q <= boot_btn_n;
      btn_sync_q <= btn_meta_q;
    end
  end

  assign btn_hold = ~btn_sync_q;
`else
  assign btn_hold = 1'b0;
`endif

  always_comb begin
    state_d           = state_q;
    por_cnt_d         = por_cnt_q;
    ab_cnt_d          = ab_cnt_q;
    dt_cnt_d          = dt_cnt_q;
    core_reset_d      = core_reset_q;
    usb_pull_en_d     = usb_pull_en_q;
    boot_now_d        = boot_now_q;
    autoboot_active_d = autoboot_active_q;

    case (state_q)
      POR: begin
        core_reset_d  = 1'b1;
        usb_pull_en_d = 1'b0;
        if (por_cnt_q == POR_W'(POR_CYCLES - 1)) begin
          por_cnt_d     = POR_W'(POR_CYCLES);
          core_reset_d  = 1'b0;
          usb_pull_en_d = 1'b1;
          ab_cnt_d      = AB_W'(AB_CYC);
          if (AUTOBOOT_MS == 0 || btn_hold) begin
            state_d = ACTIVE;
          end else begin
            state_d           = WAIT;
            autoboot_active_d = 1'b1;
          end
        end else begin
          por_cnt_d = por_cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (ab_cnt_q != '0) begin
          ab_cnt_d = ab_cnt_q - 1'b1;
        end
        // Timeout beats a simultaneous detach: the host gets no grace period.
        if (ab_cnt_q == '0) begin
          state_d           = BOOT;
          boot_now_d        = 1'b1;
          usb_pull_en_d     = 1'b0;
          autoboot_active_d = 1'b0;
        end else if (dfu_detach) begin
          state_d           = DETACH;
          dt_cnt_d          = DT_W'(DT_CYC);
          autoboot_active_d = 1'b0;
        end else if (dfu_state >= DFU_STATE_ACTIVE_MIN || btn_hold) begin
          state_d           = ACTIVE;
          autoboot_active_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (dfu_detach) begin
          state_d  = DETACH;
          dt_cnt_d = DT_W'(DT_CYC);
        end
      end
      DETACH: begin
        if (dt_cnt_q == '0) begin
          state_d       = BOOT;
          boot_now_d    = 1'b1;
          usb_pull_en_d = 1'b0;
        end else begin
          dt_cnt_d = dt_cnt_q - 1'b1;
        end
      end
      BOOT: begin
        boot_now_d    = 1'b1;
        usb_pull_en_d = 1'b0;
        core_reset_d  = 1'b0;
      end
      default: state_d = POR;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q           <= POR;
      por_cnt_q         <= '0;
      ab_cnt_q          <= '0;
      dt_cnt_q          <= '0;
      core_reset_q      <= 1'b1;
      usb_pull_en_q     <= 1'b0;
      boot_now_q        <= 1'b0;
      autoboot_active_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      por_cnt_q         <= por_cnt_d;
      ab_cnt_q          <= ab_cnt_d;
      dt_cnt_q          <= dt_cnt_d;
      core_reset_q      <= core_reset_d;
      usb_pull_en_q     <= usb_pull_en_d;
      boot_now_q        <= boot_now_d;
      autoboot_active_q <= autoboot_active_d;
    end
  end

  // Blank on the next state so the LEDs change on the same edge as the FSM.
  dfu_led_pattern #(
    .BLINK_BIT (BLINK_BIT),
    .CYLON_BIT (CYLON_BIT)
  ) u_led (
    .clk    (clk),
    .resetn (resetn),
    .idle   (dfu_state == DFU_STATE_IDLE),
    .blank  (state_d == POR || state_d == BOOT),
    .led_n  (led_n)
  );

  assign core_reset      = core_reset_q;
  assign usb_pull_en     = usb_pull_en_q;
  assign boot_now        = boot_now_q;
  assign autoboot_active = autoboot_active_q;

endmodule

// File: tb/tb_dfu_boot_ctrl.sv
// tb/tb_dfu_boot_ctrl.sv - self-checking bench for dfu_boot_ctrl
module tb_dfu_boot_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] dfu_state = 8'h02;
  logic       dfu_detach = 1'b0;
  logic       core_reset, usb_pull_en, boot_now, autoboot_active;
  logic [2:0] led_n;
`ifdef BOOT_BUTTON_EN
  logic       boot_btn_n = 1'b1;
`endif

  always #5 clk = ~clk;

  dfu_boot_ctrl #(
    .CLK_HZ      (1000),
    .POR_CYCLES  (4),
    .AUTOBOOT_MS (20),
    .DETACH_MS   (3),
    .BLINK_BIT   (3),
    .CYLON_BIT   (2)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .dfu_state       (dfu_state),
    .dfu_detach      (dfu_detach),
`ifdef BOOT_BUTTON_EN
    .boot_btn_n      (boot_btn_n),
`endif
    .core_reset      (core_reset),
    .usb_pull_en     (usb_pull_en),
    .boot_now        (boot_now),
    .autoboot_active (autoboot_active),
    .led_n           (led_n)
  );

  typedef struct {
    string      name;
    int         st_cyc;
    logic [7:0] st_val;
    int         det_cyc;
    int         exp_boot;
    int         exp_ab_fall;
  } vec_t;

  localparam int LIM = 1030;

  vec_t vecs[10];
  int   exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  int cr_fall_k, usb_rise_k, usb_at_fall, ab_rise_k, ab_fall_k, boot_k;
  int sticky_bad, por_led_bad;
  int idle_bad = 0, cyl_bad = 0, cyl_order_bad = 0;
  int blink_seen = 0, cyl_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    resetn     = 1'b0;
    dfu_state  = 8'h02;
    dfu_detach = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_core_reset", int'(core_reset), 1);
    check("rst_usb_pull_en", int'(usb_pull_en), 0);
    check("rst_boot_now", int'(boot_now), 0);
    check("rst_autoboot", int'(autoboot_active), 0);
    check("rst_led_n", int'(led_n), 7);
    resetn = 1'b1;
  endtask

  // Starts right after resetn release at a falling edge; edge k is the k-th rising edge.
  task automatic run_vec(input vec_t v, input int lim);
    logic [7:0] applied;
    logic [2:0] cyl_prev;
    cr_fall_k = -1; usb_rise_k = -1; usb_at_fall = -1; ab_rise_k = -1;
    ab_fall_k = -1; boot_k = -1; sticky_bad = 0; por_led_bad = 0;
    cyl_prev = 3'b000;
    for (int k = 1; k <= lim; k++) begin
      applied    = (v.st_cyc >= 0 && k >= v.st_cyc) ? v.st_val : 8'h02;
      dfu_state  = applied;
      dfu_detach = (k == v.det_cyc);
      @(posedge clk);
      #1;
      if (cr_fall_k < 0 && !core_reset) begin
        cr_fall_k   = k;
        usb_at_fall = int'(usb_pull_en);
      end
      if (usb_rise_k < 0 && usb_pull_en) usb_rise_k = k;
      if (ab_rise_k < 0 && autoboot_active) ab_rise_k = k;
      if (ab_rise_k >= 0 && ab_fall_k < 0 && !autoboot_active) ab_fall_k = k;
      if (boot_k < 0 && boot_now) boot_k = k;
      else if (boot_k >= 0 && !boot_now) sticky_bad = 1;
      if (core_reset && led_n != 3'b111) por_led_bad = 1;
      if (!core_reset && !boot_now && k > 6) begin
        if (applied == 8'h02) begin
          if (led_n[2:1] != 2'b11) idle_bad++;
          blink_seen |= (1 << led_n[0]);
          cyl_prev = 3'b000;
        end else begin
          if (led_n != 3'b110 && led_n != 3'b101 && led_n != 3'b011) cyl_bad++;
          else cyl_seen |= (1 << led_n);
          if (cyl_prev != 3'b000 && cyl_prev != led_n && cyl_prev != 3'b101 && led_n != 3'b101)
            cyl_order_bad++;
          cyl_prev = led_n;
        end
      end
      if (k < lim) @(negedge clk);
    end
    dfu_detach = 1'b0;
  endtask

  task automatic check_vec(input vec_t v);
    int exp_boot;
    check({v.name, "_core_reset_fall"}, cr_fall_k, 4);
    check({v.name, "_usb_rise"}, usb_rise_k, 4);
    check({v.name, "_usb_at_fall"}, usb_at_fall, 1);
    check({v.name, "_ab_rise"}, ab_rise_k, 4);
    check({v.name, "_ab_fall"}, ab_fall_k, v.exp_ab_fall);
    exp_boot = exp_q.pop_front();
    check({v.name, "_boot_cycle"}, boot_k, exp_boot);
    check({v.name, "_boot_sticky"}, sticky_bad, 0);
    check({v.name, "_por_led"}, por_led_bad, 0);
    check({v.name, "_end_usb_pull_en"}, int'(usb_pull_en), (exp_boot >= 0) ? 0 : 1);
    check({v.name, "_end_core_reset"}, int'(core_reset), 0);
    if (exp_boot >= 0) check({v.name, "_boot_led_n"}, int'(led_n), 7);
  endtask

  initial begin
    vec_t v_idle, v_det;
    vecs[0] = '{"idle",          -1, 8'h02, -1, 25, 25};
    vecs[1] = '{"cancel05",      14, 8'h05, -1, -1, 14};
    vecs[2] = '{"active_detach", 14, 8'h05, 30, 34, 14};
    vecs[3] = '{"wait_detach",   -1, 8'h02, 10, 14, 10};
    vecs[4] = '{"detach_at_zero",-1, 8'h02, 25, 25, 25};
    vecs[5] = '{"detach_at_one", -1, 8'h02, 24, 28, 24};
    vecs[6] = '{"st03_at_one",   24, 8'h03, -1, -1, 24};
    vecs[7] = '{"st03_at_zero",  25, 8'h03, -1, 25, 25};
    vecs[8] = '{"st01_ignored",   5, 8'h01, -1, 25, 25};
    vecs[9] = '{"stff_cancel",    5, 8'hff, -1, -1,  5};

    for (int i = 0; i < 10; i++) begin
      reset_dut();
      exp_q.push_back(vecs[i].exp_boot);
      run_vec(vecs[i], LIM);
      check_vec(vecs[i]);
    end

    // Asynchronous reset in the middle of the detach countdown.
    v_det = vecs[3];
    v_idle = vecs[0];
    reset_dut();
    run_vec(v_det, 12);
    #2;
    resetn = 1'b0;
    #1;
    check("async_core_reset", int'(core_reset), 1);
    check("async_usb_pull_en", int'(usb_pull_en), 0);
    check("async_boot_now", int'(boot_now), 0);
    check("async_autoboot", int'(autoboot_active), 0);
    check("async_led_n", int'(led_n), 7);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    exp_q.push_back(25);
    run_vec(v_idle, LIM);
    check_vec(v_idle);

    check("led_idle_upper_off", idle_bad, 0);
    check("led_blink_both_levels", blink_seen, 3);
    check("led_cylon_legal", cyl_bad, 0);
    check("led_cylon_order", cyl_order_bad, 0);
    check("led_cylon_all_seen", cyl_seen, (1 << 6) | (1 << 5) | (1 << 3));

`ifdef BOOT_BUTTON_EN
    boot_btn_n = 1'b0;
    reset_dut();
    exp_q.push_back(-1);
    run_vec(v_idle, LIM);
    check("btn_core_reset_fall", cr_fall_k, 4);
    check("btn_ab_never", ab_rise_k, -1);
    check("btn_boot_cycle", boot_k, exp_q.pop_front());
    check("btn_usb_pull_en", int'(usb_pull_en), 1);
    boot_btn_n = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
